// File: rtl/iologic_dly_sched.sv
// Round-robin scheduler that drives IOLOGIC delay lanes with loadn/move/dir strobes,
// one lane at a time, inserting a fixed settle gap after every strobe.
module iologic_dly_sched #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STEP_W = 7,
    parameter int unsigned SETTLE = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          req,
    input  logic [LANES-1:0]          req_load,
    input  logic [LANES-1:0]          req_dir,
    input  logic [LANES*STEP_W-1:0]   req_steps,
    input  logic [LANES-1:0]          dly_cflag,
    output logic [LANES-1:0]          dly_loadn,
    output logic [LANES-1:0]          dly_move,
    output logic [LANES-1:0]          dly_dir,
    output logic [LANES-1:0]          ack,
    output logic [LANES-1:0]          err,
    output logic                      busy
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_PULSE  = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       grant_q, grant_d;
    logic                load_q, load_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic                flag_q, flag_d;
    logic [LANES-1:0]    loadn_q, loadn_d;
    logic [LANES-1:0]    move_q, move_d;
    logic [LANES-1:0]    dir_out_q, dir_out_d;
    logic [LANES-1:0]    ack_q, ack_d;
    logic [LANES-1:0]    err_q, err_d;
    logic                busy_q, busy_d;

    // A lane whose ack is on the wire is still holding req for this cycle; mask it.
    logic [LANES-1:0]    req_eff;
    logic                found;
    int unsigned         sel_idx;
    logic                flag_nxt;

    assign req_eff = req & ~ack_q;

    // Round-robin search starting at the lane after the last grant.
    always_comb begin
        found   = 1'b0;
        sel_idx = 0;
        for (int unsigned k = 1; k <= LANES; k++) begin
            int unsigned idx;
            idx = (int'(grant_q) + k) % LANES;
            if (!found && req_eff[LW'(idx)]) begin
                found   = 1'b1;
                sel_idx = idx;
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        load_d    = load_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        flag_d    = flag_q;
        flag_nxt  = flag_q;
        loadn_d   = '1;
        move_d    = '0;
        dir_out_d = dir_out_q;
        ack_d     = '0;
        err_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = LW'(sel_idx);
                    load_d  = req_load[LW'(sel_idx)];
                    dir_d   = req_dir[LW'(sel_idx)];
                    cnt_d   = req_steps[sel_idx*STEP_W +: STEP_W];
                    flag_d  = 1'b0;
                    // Loads need no direction setup, so they strobe on the next cycle.
                    state_d = req_load[LW'(sel_idx)] ? S_PULSE : S_SETUP;
                end
            end
            S_SETUP: begin
                dir_out_d[grant_q] = dir_q;
                state_d = (cnt_q == '0) ? S_DONE : S_PULSE;
            end
            S_PULSE: begin
                if (load_q) begin
                    loadn_d[grant_q] = 1'b0;
                end else begin
                    move_d[grant_q] = 1'b1;
                    cnt_d = cnt_q - STEP_W'(1);
                end
                scnt_d  = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                flag_nxt = flag_q | (~load_q & dly_cflag[grant_q]);
                flag_d   = flag_nxt;
                if (scnt_q == SW'(SETTLE - 1)) begin
                    state_d = (load_q || flag_nxt || cnt_q == '0) ? S_DONE : S_PULSE;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            S_DONE: begin
                ack_d[grant_q] = 1'b1;
                err_d[grant_q] = flag_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= LW'(LANES - 1);
            load_q    <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            scnt_q    <= '0;
            flag_q    <= 1'b0;
            loadn_q   <= '1;
            move_q    <= '0;
            dir_out_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            load_q    <= load_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            scnt_q    <= scnt_d;
            flag_q    <= flag_d;
            loadn_q   <= loadn_d;
            move_q    <= move_d;
            dir_out_q <= dir_out_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign dly_loadn = loadn_q;
    assign dly_move  = move_q;
    assign dly_dir   = dir_out_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_iologic_dly_sched.sv
// Self-checking bench for iologic_dly_sched: vector table plus reset/arbitration sequences,
// with expected completions queued at issue and compared when ack fires.
module tb_iologic_dly_sched;

    localparam int unsigned LANES  = 4;
    localparam int unsigned STEP_W = 7;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned TW     = LANES * STEP_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [LANES-1:0]  req, req_load, req_dir, dly_cflag;
    logic [TW-1:0]     req_steps;
    logic [LANES-1:0]  dly_loadn, dly_move, dly_dir, ack, err;
    logic              busy;

    iologic_dly_sched #(.LANES(LANES), .STEP_W(STEP_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_load(req_load), .req_dir(req_dir),
        .req_steps(req_steps), .dly_cflag(dly_cflag), .dly_loadn(dly_loadn),
        .dly_move(dly_move), .dly_dir(dly_dir), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int lane; bit load; bit dir; int steps; int cf_after;
        int exp_pulses; int exp_loads; int exp_lat; bit exp_err;
    } vec_t;

    typedef struct {
        int lane; int pulses; int loads; int lat; bit err;
    } exp_t;

    exp_t sbq[$];
    bit   dir_m [LANES];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int lane, input bit load, input bit dir, input int steps);
        req_load[lane] = load;
        req_dir[lane]  = dir;
        req_steps[lane*STEP_W +: STEP_W] = STEP_W'(steps);
        req[lane] = 1'b1;
        if (!load) dir_m[lane] = dir;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_loadn"}, int'(dly_loadn), int'({LANES{1'b1}}));
        chk({tag, "_move"},  int'(dly_move), 0);
        chk({tag, "_dir"},   int'(dly_dir), 0);
        chk({tag, "_ack"},   int'(ack), 0);
        chk({tag, "_err"},   int'(err), 0);
        chk({tag, "_busy"},  int'(busy), 0);
    endtask

    // Per-cycle monitor: counts strobes, measures grant-to-ack latency, retires scoreboard entries.
    task automatic run(input int n_acks, input int budget, input bit scramble,
                       input int cf_lane, input int cf_after);
        int got = 0;
        int cyc = 0;
        int grant_cyc = 0;
        bit prev_busy = 1'b0;
        int pc [LANES];
        int lc [LANES];
        int last_p [LANES];
        exp_t e;
        for (int l = 0; l < LANES; l++) begin pc[l] = 0; lc[l] = 0; last_p[l] = -1; end
        while (got < n_acks && cyc < budget) begin
            @(posedge clk); #1; cyc++;
            if (busy && !prev_busy) begin
                grant_cyc = cyc;
                if (scramble) begin
                    req_steps = TW'($urandom);
                    req_dir   = ~req_dir;
                    req_load  = ~req_load;
                end
            end
            prev_busy = busy;
            for (int l = 0; l < LANES; l++) begin
                if (dly_move[l]) begin
                    pc[l]++;
                    if (last_p[l] >= 0) chk("pulse_gap", cyc - last_p[l], 1 + SETTLE);
                    last_p[l] = cyc;
                end
                if (!dly_loadn[l]) lc[l]++;
            end
            if (cf_after > 0 && (pc[cf_lane] + lc[cf_lane]) == cf_after &&
                (dly_move[cf_lane] || !dly_loadn[cf_lane]))
                dly_cflag[cf_lane] = 1'b1;
            if (ack != '0) begin
                chk("ack_onehot", $countones(ack), 1);
                chk("err_stray", int'(err & ~ack), 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", int'(ack), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_lane", int'(ack[e.lane]), 1);
                    chk("err_val", int'(err[e.lane]), int'(e.err));
                    chk("latency", cyc - grant_cyc, e.lat);
                    chk("move_pulses", pc[e.lane], e.pulses);
                    chk("load_pulses", lc[e.lane], e.loads);
                    chk("dir_out", int'(dly_dir[e.lane]), int'(dir_m[e.lane]));
                end
                req = req & ~ack;
                dly_cflag = '0;
                got++;
            end
        end
        if (got < n_acks) chk("timeout_acks", got, n_acks);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; req_load = '0; req_dir = '0; req_steps = '0; dly_cflag = '0;
        for (int l = 0; l < LANES; l++) dir_m[l] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t vt [7];

    initial begin
        vt[0] = '{lane:1, load:0, dir:1, steps:3,  cf_after:0, exp_pulses:3, exp_loads:0, exp_lat:14, exp_err:0};
        vt[1] = '{lane:2, load:1, dir:0, steps:0,  cf_after:0, exp_pulses:0, exp_loads:1, exp_lat:5,  exp_err:0};
        vt[2] = '{lane:3, load:0, dir:1, steps:0,  cf_after:0, exp_pulses:0, exp_loads:0, exp_lat:2,  exp_err:0};
        vt[3] = '{lane:0, load:0, dir:1, steps:10, cf_after:4, exp_pulses:4, exp_loads:0, exp_lat:18, exp_err:1};
        vt[4] = '{lane:2, load:1, dir:1, steps:9,  cf_after:1, exp_pulses:0, exp_loads:1, exp_lat:5,  exp_err:0};
        vt[5] = '{lane:1, load:0, dir:0, steps:2,  cf_after:0, exp_pulses:2, exp_loads:0, exp_lat:10, exp_err:0};
        vt[6] = '{lane:0, load:1, dir:1, steps:5,  cf_after:0, exp_pulses:0, exp_loads:1, exp_lat:5,  exp_err:0};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            issue(vt[i].lane, vt[i].load, vt[i].dir, vt[i].steps);
            sbq.push_back('{lane:vt[i].lane, pulses:vt[i].exp_pulses, loads:vt[i].exp_loads,
                            lat:vt[i].exp_lat, err:vt[i].exp_err});
            run(1, vt[i].exp_lat + 20, 1'b1, vt[i].lane, vt[i].cf_after);
            repeat (2) @(posedge clk);
            #1;
        end

        // Simultaneous requests from reset: round-robin from lane 0.
        do_reset();
        issue(0, 1'b0, 1'b1, 1);
        issue(2, 1'b0, 1'b0, 1);
        issue(3, 1'b0, 1'b1, 1);
        sbq.push_back('{lane:0, pulses:1, loads:0, lat:6, err:0});
        sbq.push_back('{lane:2, pulses:1, loads:0, lat:6, err:0});
        sbq.push_back('{lane:3, pulses:1, loads:0, lat:6, err:0});
        run(3, 100, 1'b0, 0, 0);
        chk("rr_queue_drained", sbq.size(), 0);

        // Reset in the middle of a 5-step move, then restart with the full count.
        do_reset();
        issue(1, 1'b0, 1'b1, 5);
        begin
            int pulses = 0;
            int n = 0;
            while (pulses < 2 && n < 40) begin
                @(posedge clk); #1; n++;
                if (dly_move[1]) pulses++;
            end
            chk("pre_reset_pulses", pulses, 2);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int l = 0; l < LANES; l++) dir_m[l] = 1'b0;
        dir_m[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_ack", int'(ack | err), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back('{lane:1, pulses:5, loads:0, lat:22, err:0});
        run(1, 60, 1'b0, 0, 0);
        chk("final_queue_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
